// File: rtl/gbsha_fir_core.sv
// N-tap unsigned FIR: serial coefficient load after reset, then a streaming tap delay line
// with one registered sum-of-products per accepted sample. Define FIR_SATURATE_EN to clamp y_out.

module gbsha_fir_tap #(
  parameter int BW_in = 6
) (
  input  logic [BW_in-1:0]   coeff,
  input  logic [BW_in-1:0]   x,
  output logic [2*BW_in-1:0] prod
);
  assign prod = coeff * x;
endmodule

module gbsha_fir_core #(
  parameter int N_TAPS    = 4,
  parameter int BW_in     = 6,
  parameter int BW_out    = 8,
  parameter int OUT_SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BW_in-1:0]  x_in,
  output logic [BW_out-1:0] y_out,
  output logic              out_valid,
  output logic              coeff_done
);
  localparam int BW_ACC = 2*BW_in + $clog2(N_TAPS);
  localparam int IDX_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int STAGES = 1;

  typedef enum logic {LOAD, RUN} state_t;

  state_t                           state, state_nxt;
  logic [IDX_W-1:0]                 load_idx;
  logic [N_TAPS-1:0][BW_in-1:0]     coeff, x_dl;
  logic [N_TAPS-1:0][2*BW_in-1:0]   prod;
  logic [BW_ACC-1:0]                acc, acc_sh;
  logic [BW_out-1:0]                y_sel;
  logic                             load_en, load_last, accept;
  // [0]: sample shifted in last edge, [1]: y_out updated last edge
  logic [STAGES:0]                  vld_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    accept    = 1'b0;
    load_last = (load_idx == IDX_W'(N_TAPS-1));
    case (state)
      LOAD: if (in_valid) begin
        load_en = 1'b1;
        if (load_last) state_nxt = RUN;
      end
      RUN:  accept = in_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_idx <= '0;
      coeff    <= '0;
    end else if (load_en) begin
      coeff[load_idx] <= x_in;
      load_idx        <= load_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_dl <= '0;
    end else if (accept) begin
      x_dl[0] <= x_in;
      for (int k = 1; k < N_TAPS; k++) x_dl[k] <= x_dl[k-1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_TAPS; g++) begin : g_tap
      gbsha_fir_tap #(.BW_in(BW_in)) u_tap (
        .coeff (coeff[g]),
        .x     (x_dl[g]),
        .prod  (prod[g])
      );
    end
  endgenerate

  always_comb begin
    acc = '0;
    for (int k = 0; k < N_TAPS; k++) acc = acc + BW_ACC'(prod[k]);
    acc_sh = acc >> OUT_SHIFT;
  end

`ifdef FIR_SATURATE_EN
  logic [BW_ACC-1:0] sat_max;
  always_comb begin
    sat_max               = '0;
    sat_max[BW_out-1:0]   = '1;
    y_sel = (acc_sh > sat_max) ? {BW_out{1'b1}} : BW_out'(acc_sh);
  end
`else
  assign y_sel = BW_out'(acc_sh);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      y_out    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
      if (vld_pipe[0]) y_out <= y_sel;
    end
  end

  assign out_valid  = vld_pipe[STAGES];
  assign coeff_done = (state == RUN);
endmodule
